// File: rtl/paddle_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | paddle_if : frame strobe, button and position bundle for a paddle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface paddle_if;
   logic       frame_tick;
   logic       btn_up;
   logic       btn_down;
   logic       freeze;
   logic [9:0] paddle_y;
   logic       moving_up;
   logic       moving_dn;
   logic       at_top;
   logic       at_bottom;

   modport master (
      output frame_tick, btn_up, btn_down, freeze,
      input  paddle_y, moving_up, moving_dn, at_top, at_bottom
   );

   modport slave (
      input  frame_tick, btn_up, btn_down, freeze,
      output paddle_y, moving_up, moving_dn, at_top, at_bottom
   );
endinterface
`default_nettype wire

// File: rtl/paddle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | paddle_controller : button-driven paddle with per-frame acceleration |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module paddle_controller #(
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned PADDLE_H    = 80,
   parameter int unsigned INIT_Y      = 200,
   parameter int unsigned STEP_SLOW   = 2,
   parameter int unsigned STEP_FAST   = 6,
   parameter int unsigned HOLD_FRAMES = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   paddle_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MOVE_UP = 2'd1,
      MOVE_DN = 2'd2
   } state_t;

   localparam logic [10:0] c_max_y     = 11'(SCREEN_H - PADDLE_H);
   localparam logic [9:0]  c_init_y    = 10'(INIT_Y);
   localparam logic [10:0] c_step_slow = 11'(STEP_SLOW);
   localparam logic [10:0] c_step_fast = 11'(STEP_FAST);
   localparam logic [4:0]  c_hold_max  = 5'(HOLD_FRAMES);

   logic       up_meta_q, up_s_q;
   logic       dn_meta_q, dn_s_q;
   state_t     state_q, state_d;
   logic [4:0] hold_q, hold_d;
   logic [9:0] paddle_y_q, paddle_y_d;

   logic [10:0] y_ext_w;
   logic [10:0] step_w;
   logic [10:0] y_next_w;

   // Buttons are asynchronous levels; only the second flop feeds logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_meta_q <= 1'b0;
         up_s_q    <= 1'b0;
         dn_meta_q <= 1'b0;
         dn_s_q    <= 1'b0;
      end else begin
         up_meta_q <= bus.btn_up;
         up_s_q    <= up_meta_q;
         dn_meta_q <= bus.btn_down;
         dn_s_q    <= dn_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hold_q     <= 5'd0;
         paddle_y_q <= c_init_y;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         paddle_y_q <= paddle_y_d;
      end
   end

   always_comb begin
      state_d = IDLE;
      if (!bus.freeze) begin
         case ({up_s_q, dn_s_q})
            2'b10:   state_d = MOVE_UP;
            2'b01:   state_d = MOVE_DN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Any direction change, including a straight reversal, restarts at the slow step.
   always_comb begin
      hold_d = hold_q;
      if (bus.freeze || (state_q == IDLE) || (state_d != state_q)) begin
         hold_d = 5'd0;
      end else if (bus.frame_tick && (hold_q < c_hold_max)) begin
         hold_d = hold_q + 5'd1;
      end
   end

   assign y_ext_w = {1'b0, paddle_y_q};
   assign step_w  = (hold_q < c_hold_max) ? c_step_slow : c_step_fast;

   always_comb begin
      y_next_w = y_ext_w;
      if (bus.frame_tick && !bus.freeze) begin
         case (state_q)
            MOVE_UP: y_next_w = (y_ext_w < step_w) ? 11'd0 : (y_ext_w - step_w);
            MOVE_DN: y_next_w = y_ext_w + step_w;
            default: y_next_w = y_ext_w;
         endcase
      end
   end

   // The 11-bit sum can exceed the bottom limit but never 10 bits' worth of wrap.
   always_comb begin
      paddle_y_d = y_next_w[9:0];
      if (y_next_w > c_max_y) begin
         paddle_y_d = c_max_y[9:0];
      end
   end

   assign bus.paddle_y  = paddle_y_q;
   assign bus.moving_up = (state_q == MOVE_UP);
   assign bus.moving_dn = (state_q == MOVE_DN);
   assign bus.at_top    = (paddle_y_q == 10'd0);
   assign bus.at_bottom = (y_ext_w == c_max_y);

endmodule
`default_nettype wire
